// File: rtl/timer_device_if.sv
// CPU device-bus bundle for the timer: address/strobes/store data in, read data, decode hit and IRQ out.
interface timer_device_if;
  logic [31:0] Address;
  logic        writeEn;
  logic        readEn;
  logic [31:0] writeData;
  logic [31:0] Device_Read_Data;
  logic        hit;
  logic        IRQ;

  modport master (
    output Address, writeEn, readEn, writeData,
    input  Device_Read_Data, hit, IRQ
  );

  modport slave (
    input  Address, writeEn, readEn, writeData,
    output Device_Read_Data, hit, IRQ
  );
endinterface

// File: rtl/timer_device.sv
// Memory-mapped 32-bit down-counting timer (CTRL/PRESET/COUNT), one-shot or auto-reload, registered IRQ.
// Writes land on the next edge, reads are zero-cycle combinational; no backpressure, the bus is always accepted.
module timer_device #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic           clk,
  input  logic           reset,
  timer_device_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      state_q, state_d;
  logic        en_q;
  logic [1:0]  mode_q;
  logic        im_q;
  logic [31:0] preset_q;
  logic [31:0] count_q, count_d;
  logic        pending_q;
  logic        irq_q;
  logic        en_clr;

  logic [1:0]  offset;
  logic        auto_reload;
  logic        wr_ctrl, wr_preset;
  logic        pending;
  logic [1:0]  unused_addr_bits;

  assign offset           = bus.Address[3:2];
  assign unused_addr_bits = bus.Address[1:0];
  assign bus.hit          = (bus.Address[31:4] == BASE_ADDR[31:4]) && (offset != 2'b11);
  assign auto_reload      = (mode_q == 2'b01);
  assign wr_ctrl          = bus.writeEn && bus.hit && (offset == 2'b00);
  assign wr_preset        = bus.writeEn && bus.hit && (offset == 2'b01);

  // pending is live during INT so IRQ follows one cycle later; one-shot latches it until a CTRL write
  assign pending = (state_q == INT) || pending_q;
  assign bus.IRQ = irq_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    en_clr  = 1'b0;
    case (state_q)
      IDLE: if (en_q) state_d = LOAD;
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!en_q) begin
          state_d = IDLE;
        end else if (count_q <= 32'd1) begin
          count_d = '0;
          state_d = INT;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      INT: begin
        if (auto_reload) begin
          state_d = LOAD;
        end else begin
          en_clr  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      en_q      <= 1'b0;
      mode_q    <= 2'b00;
      im_q      <= 1'b0;
      preset_q  <= '0;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      irq_q   <= pending && im_q;

      // a CPU write to CTRL takes priority over the hardware EN clear
      if (wr_ctrl) begin
        {im_q, mode_q, en_q} <= bus.writeData[3:0];
      end else if (en_clr) begin
        en_q <= 1'b0;
      end

      if (wr_preset) preset_q <= bus.writeData;

      if (wr_ctrl) begin
        pending_q <= 1'b0;
      end else if (state_q == INT && !auto_reload) begin
        pending_q <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.Device_Read_Data = '0;
    if (bus.readEn && bus.hit) begin
      case (offset)
        2'b00:   bus.Device_Read_Data = {28'd0, im_q, mode_q, en_q};
        2'b01:   bus.Device_Read_Data = preset_q;
        2'b10:   bus.Device_Read_Data = count_q;
        default: bus.Device_Read_Data = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_timer_device.sv
// Bench for timer_device: expected values queued as stimulus is applied, popped and compared on observation.
module tb_timer_device;
  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  timer_device_if bus();

  timer_device #(.BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_pass   = 0;
  int          n_checks = 0;
  string       tag_q[$];
  logic [31:0] val_q[$];
  logic [31:0] v;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  task automatic push_exp(input string tag, input logic [31:0] val);
    tag_q.push_back(tag);
    val_q.push_back(val);
  endtask

  task automatic pop_chk(input logic [31:0] got);
    if (tag_q.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      chk(tag_q.pop_front(), got, val_q.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    bus.Address   = BASE + {24'd0, off};
    bus.writeData = d;
    bus.writeEn   = 1'b1;
    tick();
    bus.writeEn   = 1'b0;
  endtask

  task automatic rd(input logic [7:0] off, output logic [31:0] d);
    bus.Address = BASE + {24'd0, off};
    bus.readEn  = 1'b1;
    #1;
    d = bus.Device_Read_Data;
    bus.readEn  = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.Address   = '0;
    bus.writeEn   = 1'b0;
    bus.readEn    = 1'b0;
    bus.writeData = '0;

    // reset state
    do_reset(2);
    push_exp("rst_ctrl", 32'd0);   rd(8'h0, v); pop_chk(v);
    push_exp("rst_preset", 32'd0); rd(8'h4, v); pop_chk(v);
    push_exp("rst_count", 32'd0);  rd(8'h8, v); pop_chk(v);
    push_exp("rst_irq", 32'd0);    pop_chk({31'd0, bus.IRQ});
    push_exp("rst_rdata_noren", 32'd0); pop_chk(bus.Device_Read_Data);

    // one-shot with interrupt enabled: PRESET=5, CTRL=0x9
    wr(8'h4, 32'd5);
    wr(8'h0, 32'h9);
    tick(); tick();
    for (int c = 5; c >= 0; c--) push_exp("os_count", c);
    for (int i = 0; i < 6; i++) begin
      rd(8'h8, v); pop_chk(v);
      if (i < 5) tick();
    end
    push_exp("os_irq_in_int", 32'd0); pop_chk({31'd0, bus.IRQ});
    tick();
    push_exp("os_irq_rise", 32'd1); pop_chk({31'd0, bus.IRQ});
    push_exp("os_ctrl_en_clr", 32'h8); rd(8'h0, v); pop_chk(v);
    repeat (3) tick();
    push_exp("os_irq_hold", 32'd1); pop_chk({31'd0, bus.IRQ});
    push_exp("os_count_hold", 32'd0); rd(8'h8, v); pop_chk(v);
    wr(8'h0, 32'h0);
    tick();
    push_exp("os_irq_cleared", 32'd0); pop_chk({31'd0, bus.IRQ});

    // auto-reload: PRESET=3, CTRL=0xB gives a one-cycle IRQ every 5 cycles
    do_reset(1);
    wr(8'h4, 32'd3);
    wr(8'h0, 32'hB);
    for (int t = 1; t <= 22; t++) begin
      tick();
      push_exp("ar_irq", (t >= 6 && (t - 6) % 5 == 0) ? 32'd1 : 32'd0);
      pop_chk({31'd0, bus.IRQ});
      if (t % 5 == 2) begin
        push_exp("ar_reload", 32'd3);
        rd(8'h8, v); pop_chk(v);
      end
    end
    wr(8'h0, 32'h0);

    // masked interrupt: PRESET=2, CTRL=0x1
    do_reset(1);
    wr(8'h4, 32'd2);
    wr(8'h0, 32'h1);
    for (int t = 1; t <= 8; t++) begin
      tick();
      push_exp("mask_irq", 32'd0); pop_chk({31'd0, bus.IRQ});
    end
    push_exp("mask_count", 32'd0); rd(8'h8, v); pop_chk(v);
    push_exp("mask_ctrl", 32'd0);  rd(8'h0, v); pop_chk(v);

    // reset in the middle of a count
    wr(8'h4, 32'd10);
    wr(8'h0, 32'h9);
    repeat (5) tick();
    push_exp("mid_pre_count", 32'd7); rd(8'h8, v); pop_chk(v);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    push_exp("mid_rst_count", 32'd0); rd(8'h8, v); pop_chk(v);
    push_exp("mid_rst_irq", 32'd0);   pop_chk({31'd0, bus.IRQ});
    push_exp("mid_rst_ctrl", 32'd0);  rd(8'h0, v); pop_chk(v);

    // PRESET update and disable mid-count, then re-enable
    do_reset(1);
    wr(8'h4, 32'd10);
    wr(8'h0, 32'h1);
    repeat (6) tick();
    push_exp("upd_count6", 32'd6); rd(8'h8, v); pop_chk(v);
    wr(8'h4, 32'd4);
    push_exp("upd_count5", 32'd5); rd(8'h8, v); pop_chk(v);
    tick();
    push_exp("upd_count4", 32'd4); rd(8'h8, v); pop_chk(v);
    wr(8'h0, 32'h0);
    push_exp("dis_count3", 32'd3); rd(8'h8, v); pop_chk(v);
    repeat (3) tick();
    push_exp("dis_hold3", 32'd3); rd(8'h8, v); pop_chk(v);
    wr(8'h0, 32'h1);
    tick();
    push_exp("reen_load", 32'd3); rd(8'h8, v); pop_chk(v);
    tick();
    push_exp("reen_new_preset", 32'd4); rd(8'h8, v); pop_chk(v);

    // address decode
    do_reset(1);
    wr(8'h4, 32'd7);
    wr(8'h0, 32'h8);
    wr(8'h0C, 32'hDEAD_BEEF);
    push_exp("dec_hit_0c", 32'd0); pop_chk({31'd0, bus.hit});
    wr(8'h10, 32'hDEAD_BEEF);
    push_exp("dec_hit_10", 32'd0); pop_chk({31'd0, bus.hit});
    push_exp("dec_ctrl", 32'h8);   rd(8'h0, v); pop_chk(v);
    push_exp("dec_hit_00", 32'd1); pop_chk({31'd0, bus.hit});
    push_exp("dec_preset", 32'd7); rd(8'h4, v); pop_chk(v);
    wr(8'h8, 32'h0000_1234);
    push_exp("dec_count_ro", 32'd0); rd(8'h8, v); pop_chk(v);
    bus.Address = BASE;
    bus.readEn  = 1'b0;
    #1;
    push_exp("dec_noren", 32'd0); pop_chk(bus.Device_Read_Data);

    chk("sb_leftover", tag_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/timer_device.md
# timer_device

Memory-mapped 32-bit down-counting timer peripheral on the CPU's device bus, alongside the existing `Device` block. It decodes `Address`, `writeEn` and `DeviceData` from the CPU. It returns register contents on `Device_Read_Data` and raises `IRQ` when a count expires. It has three registers (CTRL, PRESET, COUNT), a four-state counting FSM, and one-shot and auto-reload modes.

## Interface
- `BASE_ADDR`, default 32'h0000_7F00: word-aligned base address; register window is BASE_ADDR..BASE_ADDR+8.
- `clk`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high; sampled on the rising edge of `clk`.
- `Address`  in  32: byte address from the CPU. Bits [1:0] are ignored.
- `writeEn`  in  1: CPU store strobe, qualified by the address match.
- `readEn`  in  1: read enable, qualified by the address match.
- `writeData`  in  32: store data, driven by the CPU's `DeviceData`.
- `Device_Read_Data`  out  32: read data, combinational from registers.
- `hit`  out  1: address is inside the register window. The integrator uses it to mux read data.
- `IRQ`  out  1: interrupt request, registered.

## Operation
- Register map, as offset from BASE_ADDR:
  - 0x0 CTRL (R/W): bit0 EN, bits[2:1] MODE (00 one-shot, 01 auto-reload, 1x reserved and treated as 00), bit3 IM (interrupt mask, 1 = enabled). Bits [31:4] read as 0.
  - 0x4 PRESET (R/W): 32-bit reload value.
  - 0x8 COUNT (read-only): current count. Writes to it are ignored.
- Address decode: `hit` = (Address[31:4] == BASE_ADDR[31:4]) && (Address[3:2] != 2'b11). Offset 0xC is unmapped.
- Write: when `writeEn && hit`, the addressed register updates on the next edge.
- Read: `Device_Read_Data` = (`readEn && hit`) ? register : 0.
- FSM states:
  - IDLE: COUNT holds. If EN=1, next state is LOAD.
  - LOAD: COUNT <= PRESET, then go to CNT.
  - CNT:
    - If EN=0, go to IDLE and hold COUNT.
    - Else if COUNT ≤ 1, COUNT <= 0 and go to INT.
    - Else COUNT <= COUNT-1.
  - INT: sets `pending`.
    - MODE 00: clear CTRL.EN (hardware write), then go to IDLE.
    - MODE 01: go to LOAD.
- `IRQ` = registered (`pending` & IM).
  - MODE 00: `pending` stays set until any CPU write to CTRL.
  - MODE 01: `pending` lasts one cycle (set in INT, cleared on leaving it). This gives a one-cycle `IRQ` pulse per period.
- Counter arithmetic is unsigned 32-bit. COUNT never wraps below 0. PRESET=0 or 1 expires on the first CNT cycle.
- Boundary behaviour:
  - CPU write to CTRL in the same cycle as the INT-state EN clear: the CPU value wins.
  - PRESET write during CNT: COUNT is unaffected; the new value loads on the next LOAD.
  - EN cleared during LOAD: LOAD still completes, then CNT sees EN=0 and goes to IDLE.
  - `reset` mid-count: all state is cleared immediately on that edge.

## Timing
- Reset values: CTRL=0, PRESET=0, COUNT=0, state=IDLE, `pending`=0, `IRQ`=0. With `readEn`=0, `Device_Read_Data`=0.
- Write latency: register visible on reads the cycle after the write edge.
- Enable to first decrement:
  - Edge E: EN written, state still IDLE.
  - E+1: enter LOAD.
  - E+2: COUNT=PRESET, state=CNT.
  - E+3: COUNT=PRESET-1.
- Expiry: PRESET=N≥1 gives INT N cycles after COUNT=PRESET, and `IRQ` high one cycle after INT.
- Auto-reload period: N+2 cycles (LOAD + N CNT + INT).
- Read path is combinational. Address to `Device_Read_Data` is zero-cycle.

## Test plan
- Reset: hold `reset` 2 cycles → all registers read 0 and `IRQ`=0. Apply reset mid-count → COUNT reads 0 and `IRQ`=0 on the next cycle.
- One-shot, interrupt masked in: write PRESET=5, then CTRL=0x9 → COUNT sequence 5,4,3,2,1,0. `IRQ` rises and stays high; CTRL reads 0x8 (EN cleared). Write CTRL=0 → `IRQ` low the next cycle.
- Auto-reload: PRESET=3, CTRL=0xB → `IRQ` one-cycle pulses exactly every 5 cycles for 4 periods. COUNT reloads to 3 each period.
- Masked interrupt: PRESET=2, CTRL=0x1 → COUNT reaches 0 and EN clears; `IRQ` never asserts.
- Disable and PRESET update mid-count: PRESET=10, enable, and at COUNT=6 write PRESET=4 → COUNT continues 5,4… Then write CTRL=0 at COUNT=3 → COUNT holds at 3. Re-enable → COUNT reloads to 4.
- Decode: write 0xDEADBEEF to BASE+0xC, then to BASE+0x10 → no register changes and `hit`=0. Write to BASE+0x8 → COUNT unchanged. Reads at BASE+0x0 with `readEn`=0 return 0.
